// File: rtl/arduino_link_tx.sv
// arduino_link_tx: sends {ctrl, ball, val} to the Arduino as a 4-byte 8N1 frame
// whenever the word changes, plus a periodic heartbeat resend while idle.
module arduino_link_tx #(
   parameter int CLKS_PER_BIT   = 434,
   parameter int HEARTBEAT_CLKS = 5000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  ball_i,
   input  logic [1:0]  ctrl_i,
   input  logic [4:0]  val_i,
   output logic        uart_tx,
   output logic        busy,
   output logic [15:0] frames_sent
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [31:0] HB_MAX   = 32'(HEARTBEAT_CLKS);
   localparam logic [7:0]  SYNC     = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state, state_n;
   logic [9:0]  word;
   logic [9:0]  last_w, last_n;
   logic [9:0]  frame_w, frame_n;
   logic [15:0] clk_cnt, clk_cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [1:0]  byte_idx, byte_idx_n;
   logic [31:0] hb_cnt, hb_n;
   logic        tx_n, busy_n;
   logic [15:0] frames_n;
   logic [7:0]  b1, b2, cur_byte;
   logic        bit_end, hb_due, trigger;

   assign word    = {ctrl_i, ball_i, val_i};
   assign b1      = frame_w[7:0];
   assign b2      = {6'b0, frame_w[9:8]};
   assign bit_end = (clk_cnt == BIT_LAST);
   assign hb_due  = (HEARTBEAT_CLKS != 0) && (hb_cnt == HB_MAX);
   assign trigger = (state == IDLE) && ((word != last_w) || hb_due);

   always_comb begin
      cur_byte = SYNC ^ b1 ^ b2;
      unique case (byte_idx)
         2'd0:    cur_byte = SYNC;
         2'd1:    cur_byte = b1;
         2'd2:    cur_byte = b2;
         default: cur_byte = SYNC ^ b1 ^ b2;
      endcase
   end

   always_comb begin
      state_n    = state;
      tx_n       = uart_tx;
      busy_n     = busy;
      frames_n   = frames_sent;
      last_n     = last_w;
      frame_n    = frame_w;
      clk_cnt_n  = clk_cnt + 16'd1;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      hb_n       = hb_cnt;
      unique case (state)
         IDLE: begin
            clk_cnt_n = '0;
            if (trigger) begin
               // snapshot so later input changes never touch this frame
               state_n    = START;
               tx_n       = 1'b0;
               busy_n     = 1'b1;
               last_n     = word;
               frame_n    = word;
               hb_n       = '0;
               bit_idx_n  = '0;
               byte_idx_n = '0;
            end else if (hb_cnt != HB_MAX) begin
               hb_n = hb_cnt + 32'd1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               clk_cnt_n = '0;
               bit_idx_n = '0;
               tx_n      = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               clk_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = cur_byte[bit_idx_n];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               clk_cnt_n = '0;
               if (byte_idx != 2'd3) begin
                  state_n    = START;
                  tx_n       = 1'b0;
                  byte_idx_n = byte_idx + 2'd1;
               end else begin
                  state_n    = IDLE;
                  tx_n       = 1'b1;
                  busy_n     = 1'b0;
                  frames_n   = frames_sent + 16'd1;
                  byte_idx_n = '0;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         uart_tx     <= 1'b1;
         busy        <= 1'b0;
         frames_sent <= '0;
         last_w      <= '0;
         frame_w     <= '0;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         byte_idx    <= '0;
         hb_cnt      <= '0;
      end else begin
         state       <= state_n;
         uart_tx     <= tx_n;
         busy        <= busy_n;
         frames_sent <= frames_n;
         last_w      <= last_n;
         frame_w     <= frame_n;
         clk_cnt     <= clk_cnt_n;
         bit_idx     <= bit_idx_n;
         byte_idx    <= byte_idx_n;
         hb_cnt      <= hb_n;
      end
   end

endmodule

// File: tb/tb_arduino_link_tx.sv
// Directed bench for arduino_link_tx: frame decode, bit timing, heartbeat,
// reset abort and frame counter wrap.
module tb_arduino_link_tx;

   localparam int CPB = 4;
   localparam int HB  = 1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  ball = '0;
   logic [1:0]  ctrl = '0;
   logic [4:0]  val = '0;
   logic        tx, busy, tx0, busy0;
   logic [15:0] fs, fs0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   arduino_link_tx #(.CLKS_PER_BIT(CPB), .HEARTBEAT_CLKS(HB)) dut (
      .clk(clk), .reset_n(reset_n), .ball_i(ball), .ctrl_i(ctrl),
      .val_i(val), .uart_tx(tx), .busy(busy), .frames_sent(fs)
   );

   arduino_link_tx #(.CLKS_PER_BIT(CPB), .HEARTBEAT_CLKS(0)) dut_nohb (
      .clk(clk), .reset_n(reset_n), .ball_i(ball), .ctrl_i(ctrl),
      .val_i(val), .uart_tx(tx0), .busy(busy0), .frames_sent(fs0)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_w(input logic [9:0] w);
      {ctrl, ball, val} = w;
   endtask

   // waits for the start bit, then decodes 40 bit times of 4 samples each
   task automatic check_frame(input string tag, input int limit,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, output int start);
      int n = 0;
      bit ok = 1'b1;
      logic first;
      logic [7:0] b [4];
      while (tx !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      start = cyc;
      if (tx !== 1'b0) begin
         chk({tag, "_start"}, 32'(tx), 32'd0);
         return;
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 10; j++) begin
            first = tx;
            for (int k = 0; k < CPB; k++) begin
               if (tx !== first || busy !== 1'b1) ok = 1'b0;
               @(negedge clk);
            end
            if (j == 0 && first !== 1'b0) ok = 1'b0;
            if (j == 9 && first !== 1'b1) ok = 1'b0;
            if (j > 0 && j < 9) b[i][j-1] = first;
         end
      end
      chk({tag, "_b0"}, 32'(b[0]), 32'hA5);
      chk({tag, "_b1"}, 32'(b[1]), 32'(e1));
      chk({tag, "_b2"}, 32'(b[2]), 32'(e2));
      chk({tag, "_b3"}, 32'(b[3]), 32'(e3));
      chk({tag, "_timing"}, 32'(ok), 32'd1);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   task automatic watch(input int n, output int rises, output int rises0,
                        output int tx_lows);
      logic pb, pb0;
      pb = busy;
      pb0 = busy0;
      rises = 0;
      rises0 = 0;
      tx_lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (busy === 1'b1 && pb !== 1'b1) rises++;
         if (busy0 === 1'b1 && pb0 !== 1'b1) rises0++;
         if (tx !== 1'b1) tx_lows++;
         pb = busy;
         pb0 = busy0;
      end
   endtask

   initial begin
      int s1, sa, sb, sh, sw, idle, r, r0, lows, n;
      set_w(10'h000);
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frames", 32'(fs), 32'd0);
      reset_n = 1'b1;
      watch(20, r, r0, lows);
      chk("quiet_after_rst", 32'(r), 32'd0);

      // ctrl=10 ball=101 val=10011
      set_w({2'b10, 3'b101, 5'b10011});
      check_frame("f1", 10, 8'hB3, 8'h02, 8'h14, s1);
      chk("f1_frames", 32'(fs), 32'd1);

      // frame A in flight while W moves twice; only the last value follows
      set_w({2'b11, 3'b111, 5'b00000});
      fork
         check_frame("fa", 10, 8'hE0, 8'h03, 8'h46, sa);
         begin
            repeat (40) @(negedge clk);
            set_w(10'h2AA);
            repeat (40) @(negedge clk);
            set_w(10'h155);
         end
      join
      chk("fa_frames", 32'(fs), 32'd2);
      check_frame("fb", 10, 8'h55, 8'h01, 8'hF1, sb);
      chk("fb_gap", 32'(sb - sa), 32'd161);
      chk("fb_frames", 32'(fs), 32'd3);
      watch(200, r, r0, lows);
      chk("no_extra_frame", 32'(r), 32'd0);

      check_frame("hb", 1500, 8'h55, 8'h01, 8'hF1, sh);
      idle = sh - (sb + 160);
      chk("hb_gap_ok", 32'((idle == HB) || (idle == HB + 1)), 32'd1);
      chk("hb_frames", 32'(fs), 32'd4);

      watch(10000, r, r0, lows);
      chk("nohb_quiet", 32'(r0), 32'd0);
      chk("nohb_frames", 32'(fs0), 32'd3);

      // reset at sample 70 of a frame
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      set_w(10'h0F0);
      n = 0;
      while (tx !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rf_start", 32'(tx), 32'd0);
      repeat (70) @(negedge clk);
      chk("rf_busy_mid", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rf_tx", 32'(tx), 32'd1);
      chk("rf_busy", 32'(busy), 32'd0);
      chk("rf_frames", 32'(fs), 32'd0);
      set_w(10'h000);
      @(negedge clk);
      chk("rf_tx_hold", 32'(tx), 32'd1);
      reset_n = 1'b1;
      watch(300, r, r0, lows);
      chk("rf_line_high", 32'(lows), 32'd0);
      chk("rf_no_frame", 32'(r), 32'd0);

      // counter wrap
      force dut.frames_sent = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      release dut.frames_sent;
      @(negedge clk);
      chk("wrap_pre", 32'(fs), 32'hFFFF);
      set_w(10'h155);
      check_frame("wrap", 10, 8'h55, 8'h01, 8'hF1, sw);
      chk("wrap_frames", 32'(fs), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
